// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state codes and default
// sizing used by the sequencer, divider and accumulator.
package freq_meter_pkg;

  localparam int GATE_W_DEF     = 27;
  localparam int N_AVG_LOG2_DEF = 2;

  typedef enum logic [2:0] {
    FMS_IDLE  = 3'd0,
    FMS_CLEAR = 3'd1,
    FMS_GATE  = 3'd2,
    FMS_ADD   = 3'd3,
    FMS_DIV   = 3'd4,
    FMS_WAIT  = 3'd5,
    FMS_DONE  = 3'd6
  } fms_state_e;

endpackage

// File: rtl/freq_meter_sequencer_gate_timer.sv
// Gate window down-counter. Loaded with the gate length, it counts down while
// enabled and flags the final cycle of the window (count == 1).
module gate_timer #(
  parameter int GATE_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [GATE_W-1:0] load_val,
  output logic              expired
);

  localparam logic [GATE_W-1:0] ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  logic [GATE_W-1:0] cnt_q;

  // Load takes priority; the floor at zero keeps the counter from wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign expired = (cnt_q == ONE);

endmodule

// File: rtl/freq_meter_sequencer.sv
// Measurement sequencer: times gate windows for the edge counter, collects
// 2**N_AVG_LOG2 counts into the accumulator, kicks the divider and flags the
// averaged result. Outputs are decoded from registered state only.
module freq_meter_sequencer
  import freq_meter_pkg::*;
#(
  parameter int GATE_W     = GATE_W_DEF,
  parameter int N_AVG_LOG2 = N_AVG_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [GATE_W-1:0]     gate_len,
  input  logic                  div_done,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  output logic                  acc_clear,
  output logic                  acc_add,
  output logic                  div_start,
  output logic                  result_valid,
  output logic                  busy,
  output logic [N_AVG_LOG2-1:0] sample_idx
);

  localparam logic [GATE_W-1:0]     GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};
  localparam logic [N_AVG_LOG2-1:0] IDX_ONE  = {{(N_AVG_LOG2-1){1'b0}}, 1'b1};
  localparam logic [N_AVG_LOG2-1:0] IDX_LAST = '1;

  fms_state_e              state_q;
  logic [N_AVG_LOG2-1:0]   sample_idx_q;
  logic [GATE_W-1:0]       gate_q;
  logic [GATE_W-1:0]       gate_d;
  logic                    tmr_expired;

  // A zero gate length would give an empty window, so it is promoted to one cycle.
  assign gate_d = (gate_len == '0) ? GATE_ONE : gate_len;

  gate_timer #(
    .GATE_W (GATE_W)
  ) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == FMS_CLEAR),
    .enable   (state_q == FMS_GATE),
    .load_val (gate_q),
    .expired  (tmr_expired)
  );

  // Sequencer FSM with sample index and latched gate length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FMS_IDLE;
      sample_idx_q <= '0;
      gate_q       <= GATE_ONE;
    end else begin
      case (state_q)
        FMS_IDLE: begin
          if (start || continuous) begin
            gate_q  <= gate_d;
            state_q <= FMS_CLEAR;
          end
        end
        FMS_CLEAR: state_q <= FMS_GATE;
        FMS_GATE: begin
          if (tmr_expired) state_q <= FMS_ADD;
        end
        FMS_ADD: begin
          if (sample_idx_q == IDX_LAST) begin
            sample_idx_q <= '0;
            state_q      <= FMS_DIV;
          end else begin
            sample_idx_q <= sample_idx_q + IDX_ONE;
            state_q      <= FMS_CLEAR;
          end
        end
        FMS_DIV: state_q <= FMS_WAIT;
        FMS_WAIT: begin
          if (div_done) state_q <= FMS_DONE;
        end
        FMS_DONE: begin
          if (continuous) begin
            gate_q  <= gate_d;
            state_q <= FMS_CLEAR;
          end else begin
            state_q <= FMS_IDLE;
          end
        end
        default: begin
          sample_idx_q <= '0;
          state_q      <= FMS_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != FMS_IDLE);
  assign cnt_clear    = (state_q == FMS_CLEAR);
  assign acc_clear    = (state_q == FMS_CLEAR) && (sample_idx_q == '0);
  assign cnt_enable   = (state_q == FMS_GATE);
  assign acc_add      = (state_q == FMS_ADD);
  assign div_start    = (state_q == FMS_DIV);
  assign result_valid = (state_q == FMS_DONE);
  assign sample_idx   = sample_idx_q;

endmodule

// File: tb/tb_freq_meter_sequencer.sv
// Scoreboard bench for freq_meter_sequencer. Each requested average pushes its
// expected event counts and result latency; a monitor tallies the DUT outputs
// and checks them against the queue head on every result_valid pulse.
module tb_freq_meter_sequencer;

  localparam int GW  = 27;
  localparam int NL  = 2;
  localparam int GW2 = 4;

  typedef struct {
    int en;
    int clr;
    int add;
    int aclr;
    int dst;
    int lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, continuous, div_done;
  logic [GW-1:0] gate_len;
  logic          cnt_clear, cnt_enable, acc_clear, acc_add, div_start, result_valid, busy;
  logic [NL-1:0] sample_idx;

  logic           start2, continuous2, div_done2;
  logic [GW2-1:0] gate_len2;
  logic           cnt_clear2, cnt_enable2, acc_clear2, acc_add2, div_start2, result_valid2, busy2;
  logic [NL-1:0]  sample_idx2;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   dd_mode = 0;
  exp_t sb[$];

  freq_meter_sequencer #(.GATE_W(GW), .N_AVG_LOG2(NL)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .gate_len(gate_len), .div_done(div_done), .cnt_clear(cnt_clear),
    .cnt_enable(cnt_enable), .acc_clear(acc_clear), .acc_add(acc_add),
    .div_start(div_start), .result_valid(result_valid), .busy(busy),
    .sample_idx(sample_idx)
  );

  freq_meter_sequencer #(.GATE_W(GW2), .N_AVG_LOG2(NL)) dut_short (
    .clk(clk), .reset(reset), .start(start2), .continuous(continuous2),
    .gate_len(gate_len2), .div_done(div_done2), .cnt_clear(cnt_clear2),
    .cnt_enable(cnt_enable2), .acc_clear(acc_clear2), .acc_add(acc_add2),
    .div_start(div_start2), .result_valid(result_valid2), .busy(busy2),
    .sample_idx(sample_idx2)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Expected entry for one average of N=4 samples with effective gate g and WAIT length k.
  function automatic exp_t mk(input int g, input int k);
    exp_t e;
    e.en   = 4 * g;
    e.clr  = 4;
    e.add  = 4;
    e.aclr = 1;
    e.dst  = 1;
    e.lat  = 1 + 4 * (g + 2) + k;
    return e;
  endfunction

  initial begin
    int n, rv;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; gate_len = '0; div_done = 1'b0;
    start2 = 1'b0; continuous2 = 1'b0; gate_len2 = '0; div_done2 = 1'b1;

    fork
      forever @(posedge clk) cyc++;
      // div_done responder: pulse two cycles after div_start, or held high
      forever begin
        @(negedge clk);
        if (dd_mode == 1) begin
          div_done = 1'b1;
        end else if (div_start) begin
          div_done = 1'b0;
          @(negedge clk);
          @(negedge clk);
          div_done = 1'b1;
          @(negedge clk);
          div_done = 1'b0;
        end else begin
          div_done = 1'b0;
        end
      end
      // monitor: tally events per average, compare on result_valid
      begin : mon
        int t_en, t_clr, t_add, t_aclr, t_dst, t0;
        exp_t e;
        t_en = 0; t_clr = 0; t_add = 0; t_aclr = 0; t_dst = 0; t0 = 0;
        forever begin
          @(negedge clk);
          if (!busy) begin
            t_en = 0; t_clr = 0; t_add = 0; t_aclr = 0; t_dst = 0;
          end else begin
            if (cnt_enable) t_en++;
            if (cnt_clear)  t_clr++;
            if (acc_add)    t_add++;
            if (div_start)  t_dst++;
            if (acc_clear) begin
              t_aclr++;
              t0 = cyc;
            end
            if (result_valid) begin
              if (sb.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
              end else begin
                e = sb.pop_front();
                check("cnt_enable_cycles", t_en, e.en);
                check("cnt_clear_pulses", t_clr, e.clr);
                check("acc_add_pulses", t_add, e.add);
                check("acc_clear_pulses", t_aclr, e.aclr);
                check("div_start_pulses", t_dst, e.dst);
                check("result_latency", cyc - t0, e.lat);
              end
              t_en = 0; t_clr = 0; t_add = 0; t_aclr = 0; t_dst = 0;
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt_clear", int'(cnt_clear), 0);
    check("rst_cnt_enable", int'(cnt_enable), 0);
    check("rst_acc_clear", int'(acc_clear), 0);
    check("rst_acc_add", int'(acc_add), 0);
    check("rst_div_start", int'(div_start), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_sample_idx", int'(sample_idx), 0);
    check("rst_busy_short", int'(busy2), 0);
    reset = 1'b0;

    // Single shot, gate 3: result at cycle 24, busy falls the cycle after
    gate_len = GW'(3);
    sb.push_back(mk(3, 2));
    pulse_start();
    n = 1; rv = 0;
    while (!rv && n < 100) begin
      @(negedge clk);
      n++;
      rv = int'(result_valid);
    end
    check("single_result_cycle", n, 24);
    @(negedge clk);
    check("single_busy_falls", int'(busy), 0);

    // Zero gate length treated as one
    gate_len = '0;
    sb.push_back(mk(1, 2));
    pulse_start();
    wait_idle(200);

    // Continuous gate 5: two full averages, drop continuous inside the third GATE
    gate_len = GW'(5);
    sb.push_back(mk(5, 2));
    sb.push_back(mk(5, 2));
    sb.push_back(mk(5, 2));
    @(negedge clk) continuous = 1'b1;
    n = 0; rv = 0;
    while (rv < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (result_valid) rv++;
    end
    check("cont_two_results", rv, 2);
    n = 0;
    while (!cnt_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    continuous = 1'b0;
    wait_idle(300);

    // Start pulses during GATE and WAIT ignored; gate change applies next average
    gate_len = GW'(3);
    sb.push_back(mk(3, 2));
    pulse_start();
    n = 0;
    while (!cnt_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    gate_len = GW'(6);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!div_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle(200);
    sb.push_back(mk(6, 2));
    pulse_start();
    wait_idle(300);

    // Reset mid-GATE at sample 2 aborts the average silently
    gate_len = GW'(4);
    pulse_start();
    n = 0;
    while (!(cnt_enable && sample_idx == NL'(2)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt_enable", int'(cnt_enable), 0);
    check("abort_cnt_clear", int'(cnt_clear), 0);
    check("abort_acc_add", int'(acc_add), 0);
    check("abort_sample_idx", int'(sample_idx), 0);
    reset = 1'b0;
    rv = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) rv++;
    end
    check("abort_no_result", rv, 0);
    gate_len = GW'(1);
    sb.push_back(mk(1, 2));
    pulse_start();
    wait_idle(200);

    // div_done held high: one-cycle WAIT, one result
    dd_mode = 1;
    gate_len = GW'(2);
    @(negedge clk);
    sb.push_back(mk(2, 1));
    pulse_start();
    wait_idle(200);
    repeat (20) @(negedge clk);

    // Short-timer build, maximum gate length 15: no wrap
    gate_len2 = '1;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 1; rv = 0;
    begin : short_run
      int en2;
      en2 = 0;
      while (!rv && n < 200) begin
        if (cnt_enable2) en2++;
        rv = int'(result_valid2);
        if (!rv) begin
          @(negedge clk);
          n++;
        end
      end
      check("maxgate_cnt_enable", en2, 60);
      check("maxgate_result_cycle", n, 71);
    end
    @(negedge clk);
    check("maxgate_busy_falls", int'(busy2), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
